// File: rtl/ifq_pkg.sv
// Shared types for the instruction fetch queue: entry layout and pop-count encoding.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package ifq_pkg;

  localparam int IFQ_INST_W = 32;
  localparam int IFQ_PC_W   = 32;

  // Storage word layout: instruction in the upper bits, fetch address below.
  typedef struct packed {
    logic [IFQ_INST_W-1:0] inst;
    logic [IFQ_PC_W-1:0]   pc;
  } ifq_entry_t;

  // Decoder consume request; the top code is an alias for two.
  typedef enum logic [1:0] {
    POP_NONE    = 2'd0,
    POP_ONE     = 2'd1,
    POP_TWO     = 2'd2,
    POP_TWO_ALT = 2'd3
  } pop_cnt_e;

  function automatic logic [1:0] pop_clamp(input logic [1:0] req);
    return (req == POP_TWO_ALT) ? POP_TWO : req;
  endfunction

endpackage

// File: rtl/inst_fetch_queue_if.sv
// Fetch-side push handshake plus the dual-entry decoder view of the queue.
// Latency: wires only.
// Backpressure: in_ready is driven by the queue, everything else upstream/downstream.
interface inst_fetch_queue_if
  import ifq_pkg::*;
#(
  parameter int INST_WIDTH = IFQ_INST_W,
  parameter int PC_WIDTH   = IFQ_PC_W,
  parameter int DEPTH      = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  in_valid;
  logic [INST_WIDTH-1:0] in_inst;
  logic [PC_WIDTH-1:0]   in_pc;
  logic                  in_ready;
  logic [1:0]            pop_cnt;
  logic                  flush;
  logic                  out0_valid;
  logic [INST_WIDTH-1:0] out0_inst;
  logic [PC_WIDTH-1:0]   out0_pc;
  logic                  out1_valid;
  logic [INST_WIDTH-1:0] out1_inst;
  logic [PC_WIDTH-1:0]   out1_pc;
  logic [CW-1:0]         count;
  logic                  is_empty;
  logic                  is_full;
  logic                  almost_full;

  // Fetch unit / decoder side.
  modport master (
    output in_valid, in_inst, in_pc, pop_cnt, flush,
    input  in_ready, out0_valid, out0_inst, out0_pc,
           out1_valid, out1_inst, out1_pc,
           count, is_empty, is_full, almost_full
  );

  // Queue side.
  modport slave (
    input  in_valid, in_inst, in_pc, pop_cnt, flush,
    output in_ready, out0_valid, out0_inst, out0_pc,
           out1_valid, out1_inst, out1_pc,
           count, is_empty, is_full, almost_full
  );

endinterface

// File: rtl/ifq_storage_2r1w.sv
// Entry storage: one synchronous write port, two asynchronous read ports, no reset.
// Latency: write visible on the read ports the cycle after the write edge.
// Backpressure: none; the caller only writes free slots.
module ifq_storage_2r1w #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr0,
  output logic [WIDTH-1:0]         o_rdata0,
  input  logic [$clog2(DEPTH)-1:0] i_raddr1,
  output logic [WIDTH-1:0]         o_rdata1
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Write the accepted entry; contents need no reset since occupancy masks stale slots.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata0 = r_mem[i_raddr0];
  assign o_rdata1 = r_mem[i_raddr1];

endmodule

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: 1 push/cycle from fetch, 0-2 pops/cycle to decode, flushable.
// Latency: pushed entry visible on out0/out1 the cycle after the push; reads are combinational.
// Backpressure: in_ready low when full or flushing; pops beyond occupancy are trimmed.
module inst_fetch_queue
  import ifq_pkg::*;
#(
  parameter int INST_WIDTH  = IFQ_INST_W,
  parameter int PC_WIDTH    = IFQ_PC_W,
  parameter int DEPTH       = 8,
  parameter int AFULL_LEVEL = DEPTH - 2
) (
  input  logic            clk,
  input  logic            reset_n,
  inst_fetch_queue_if.slave q
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = INST_WIDTH + PC_WIDTH;
  localparam logic [CW-1:0] AFULL_CNT = CW'(AFULL_LEVEL);

  logic [CW-1:0] r_wr_ptr;
  logic [CW-1:0] r_rd_ptr;
  logic [CW-1:0] w_count;
  logic          w_empty;
  logic          w_full;
  logic          w_in_ready;
  logic          w_push;
  logic [1:0]    w_pop_req;
  logic [1:0]    w_pop;
  logic [AW-1:0] w_rd1_addr;
  logic [EW-1:0] w_rd0;
  logic [EW-1:0] w_rd1;
  logic          w_out0_vld;
  logic          w_out1_vld;

  // Occupancy comes straight from the wrap-bit pointers; no separate counter to keep in sync.
  assign w_count    = r_wr_ptr - r_rd_ptr;
  assign w_empty    = (r_wr_ptr == r_rd_ptr);
  assign w_full     = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_in_ready = !w_full && !q.flush;
  assign w_push     = q.in_valid && w_in_ready;

  // Trim the decoder's request to what is actually held so rd_ptr never passes wr_ptr.
  always_comb begin
    w_pop_req = pop_clamp(q.pop_cnt);
    w_pop     = w_pop_req;
    if (w_count < CW'(w_pop_req)) begin
      w_pop = w_count[1:0];
    end
  end

  // Pointer update: reset first, then flush discards everything including this cycle's traffic.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (q.flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + CW'(w_push);
      r_rd_ptr <= r_rd_ptr + CW'(w_pop);
    end
  end

  assign w_rd1_addr = r_rd_ptr[AW-1:0] + AW'(1);

  ifq_storage_2r1w #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_storage (
    .clk      (clk),
    .i_we     (w_push),
    .i_waddr  (r_wr_ptr[AW-1:0]),
    .i_wdata  ({q.in_inst, q.in_pc}),
    .i_raddr0 (r_rd_ptr[AW-1:0]),
    .o_rdata0 (w_rd0),
    .i_raddr1 (w_rd1_addr),
    .o_rdata1 (w_rd1)
  );

  assign w_out0_vld = !w_empty;
  assign w_out1_vld = (w_count >= CW'(2));

  assign q.in_ready    = w_in_ready;
  assign q.out0_valid  = w_out0_vld;
  assign q.out0_inst   = w_out0_vld ? w_rd0[EW-1:PC_WIDTH] : '0;
  assign q.out0_pc     = w_out0_vld ? w_rd0[PC_WIDTH-1:0]  : '0;
  assign q.out1_valid  = w_out1_vld;
  assign q.out1_inst   = w_out1_vld ? w_rd1[EW-1:PC_WIDTH] : '0;
  assign q.out1_pc     = w_out1_vld ? w_rd1[PC_WIDTH-1:0]  : '0;
  assign q.count       = w_count;
  assign q.is_empty    = w_empty;
  assign q.is_full     = w_full;
  assign q.almost_full = (w_count >= AFULL_CNT);

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue against an ordered-list reference model.
// Latency: one step per clock; outputs sampled on the low phase.
// Backpressure: model mirrors the accept/trim rules on the entry list.
module tb_inst_fetch_queue;
  import ifq_pkg::*;

  localparam int DEPTH = 8;

  logic clk;
  logic reset_n;
  int   n_vec;
  int   n_bad;

  ifq_entry_t mq[$];

  inst_fetch_queue_if #(.INST_WIDTH(32), .PC_WIDTH(32), .DEPTH(DEPTH)) q_if ();

  inst_fetch_queue #(
    .INST_WIDTH  (32),
    .PC_WIDTH    (32),
    .DEPTH       (DEPTH),
    .AFULL_LEVEL (DEPTH - 2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .q       (q_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every output to the model's view of the current (pre-edge) state.
  task automatic check_all();
    int n;
    n = mq.size();
    chk("in_ready",    q_if.in_ready,    64'((n != DEPTH) && !q_if.flush));
    chk("out0_valid",  q_if.out0_valid,  64'(n >= 1));
    chk("out0_inst",   q_if.out0_inst,   (n >= 1) ? 64'(mq[0].inst) : 64'd0);
    chk("out0_pc",     q_if.out0_pc,     (n >= 1) ? 64'(mq[0].pc)   : 64'd0);
    chk("out1_valid",  q_if.out1_valid,  64'(n >= 2));
    chk("out1_inst",   q_if.out1_inst,   (n >= 2) ? 64'(mq[1].inst) : 64'd0);
    chk("out1_pc",     q_if.out1_pc,     (n >= 2) ? 64'(mq[1].pc)   : 64'd0);
    chk("count",       q_if.count,       64'(n));
    chk("is_empty",    q_if.is_empty,    64'(n == 0));
    chk("is_full",     q_if.is_full,     64'(n == DEPTH));
    chk("almost_full", q_if.almost_full, 64'(n >= DEPTH - 2));
  endtask

  // One clock: drive, check, advance the model, clock, return inputs to idle.
  task automatic step(input bit v, input bit fl, input bit rn, input logic [1:0] pop,
                      input logic [31:0] pc);
    ifq_entry_t e;
    int         take;
    bit         was_full;
    e.inst = $urandom();
    e.pc   = pc;
    q_if.in_valid = v;
    q_if.in_inst  = e.inst;
    q_if.in_pc    = e.pc;
    q_if.pop_cnt  = pop;
    q_if.flush    = fl;
    reset_n       = rn;
    #1;
    check_all();
    if (!rn || fl) begin
      mq.delete();
    end else begin
      was_full = (mq.size() == DEPTH);
      take = (pop == 2'd3) ? 2 : int'(pop);
      if (take > mq.size()) take = mq.size();
      repeat (take) void'(mq.pop_front());
      if (v && !was_full) mq.push_back(e);
    end
    @(posedge clk);
    #1;
    q_if.in_valid = 1'b0;
    q_if.pop_cnt  = 2'd0;
    q_if.flush    = 1'b0;
    reset_n       = 1'b1;
    @(negedge clk);
  endtask

  task automatic fill(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b1, 2'd0, base + 32'(4 * i));
  endtask

  initial begin
    clk = 1'b0;
    n_vec = 0;
    n_bad = 0;
    reset_n = 1'b0;
    q_if.in_valid = 1'b0;
    q_if.in_inst  = '0;
    q_if.in_pc    = '0;
    q_if.pop_cnt  = 2'd0;
    q_if.flush    = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);

    chk("rst_in_ready", q_if.in_ready, 1);
    chk("rst_empty",    q_if.is_empty, 1);
    chk("rst_count",    q_if.count,    0);
    chk("rst_out0_pc",  q_if.out0_pc,  0);

    // Fill to full, then a ninth push must be dropped.
    fill(8, 32'h100);
    chk("full_flag",  q_if.is_full,  1);
    chk("full_ready", q_if.in_ready, 0);
    chk("full_count", q_if.count,    8);
    step(1'b1, 1'b0, 1'b1, 2'd0, 32'h120);
    chk("drop_count", q_if.count,    8);
    chk("drop_head",  q_if.out0_pc,  32'h100);

    // Drain two at a time.
    for (int k = 0; k < 4; k++) begin
      chk("drain_pc", q_if.out0_pc, 32'h100 + 32'(8 * k));
      step(1'b0, 1'b0, 1'b1, 2'd2, 32'h0);
    end
    chk("drained_empty", q_if.is_empty, 1);

    // Over-pop with a single entry.
    step(1'b1, 1'b0, 1'b1, 2'd0, 32'h200);
    chk("one_count", q_if.count,      1);
    chk("one_out1",  q_if.out1_valid, 0);
    step(1'b0, 1'b0, 1'b1, 2'd2, 32'h0);
    chk("underpop_count", q_if.count,    0);
    chk("underpop_empty", q_if.is_empty, 1);

    // Streaming through the pointer wrap at occupancy one.
    for (int i = 0; i < 20; i++) begin
      if (i > 0) chk("wrap_head", q_if.out0_pc, 32'h300 + 32'(4 * (i - 1)));
      step(1'b1, 1'b0, 1'b1, 2'd1, 32'h300 + 32'(4 * i));
      chk("wrap_count", q_if.count, 1);
    end
    step(1'b0, 1'b0, 1'b1, 2'd1, 32'h0);

    // Flush overrides push and pop.
    fill(5, 32'h400);
    chk("pre_flush_count", q_if.count, 5);
    step(1'b1, 1'b1, 1'b1, 2'd2, 32'h500);
    chk("flush_count", q_if.count,      0);
    chk("flush_empty", q_if.is_empty,   1);
    chk("flush_out0",  q_if.out0_valid, 0);

    // Reset in the middle of traffic.
    fill(6, 32'h600);
    chk("pre_rst_count", q_if.count, 6);
    chk("pre_rst_afull", q_if.almost_full, 1);
    step(1'b1, 1'b0, 1'b0, 2'd1, 32'h700);
    chk("mrst_ready", q_if.in_ready,    1);
    chk("mrst_empty", q_if.is_empty,    1);
    chk("mrst_full",  q_if.is_full,     0);
    chk("mrst_afull", q_if.almost_full, 0);
    chk("mrst_count", q_if.count,       0);
    chk("mrst_out1",  q_if.out1_valid,  0);
    check_all();

    // Randomized traffic, alternating push-heavy and pop-heavy phases.
    for (int i = 0; i < 600; i++) begin
      logic [1:0] p;
      p = ((i % 128) < 64) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3));
      step($urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0,
           $urandom_range(0, 99) != 0, p, $urandom());
    end
    check_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
